// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: default operand width and the
// Montgomery multiplier state encoding (also used by the exponentiation controller).
package rsa_pkg;
  localparam int NBITS_DEF = 256;
  localparam int CBITS_DEF = $clog2(NBITS_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: m' = (m + a*B + q*N) / 2, where q makes the sum even.
// Purely combinational so the carry chain can be constrained on its own.
module mont_step #(
  parameter int NBITS = 256
) (
  input  logic [NBITS+1:0] m,
  input  logic             a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] n,
  output logic [NBITS+1:0] m_next
);
  logic [NBITS+1:0] t_add_b;
  logic [NBITS+1:0] t_add_n;

  // With m < 2N and B < N the sum stays below 4N, so NBITS+2 bits never overflow.
  always_comb begin
    t_add_b = m + (a ? {2'b00, b} : '0);
    t_add_n = t_add_b[0] ? (t_add_b + {2'b00, n}) : t_add_b;
    m_next  = t_add_n >> 1;
  end
endmodule

// File: rtl/mont_mul.sv
// Iterative radix-2 Montgomery multiplier: out = A*B*2^(-NBITS) mod N,
// one multiplier bit per clock, NBITS+1 cycles from launch to done.
module mont_mul
  import rsa_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int CBITS = $clog2(NBITS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] A,
  input  logic [NBITS-1:0] B,
  input  logic [NBITS-1:0] N,
  output logic [NBITS-1:0] out,
  output logic             done,
  output state_t           state_dbg
);
  // Handshake: start idles high; a high->low transition (seen on a rising clk
  // edge) launches, even mid-operation, restarting with the new operands.
  // done falls on that launch edge and rises NBITS+1 edges later with out valid;
  // out holds the previous result until then.
  state_t           state, state_nxt;
  logic             prev_start;
  logic             launch;
  logic [NBITS-1:0] a_buf, b_buf, n_buf;
  logic [NBITS+1:0] m, m_next, fix_val;
  logic [CBITS-1:0] counter;

  assign launch    = prev_start & ~start;
  assign state_dbg = state;

  mont_step #(.NBITS(NBITS)) u_step (
    .m      (m),
    .a      (a_buf[0]),
    .b      (b_buf),
    .n      (n_buf),
    .m_next (m_next)
  );

  // Final conditional subtraction at full width, since m may reach 2N-1.
  assign fix_val = (m >= {2'b00, n_buf}) ? (m - {2'b00, n_buf}) : m;

  always_comb begin
    state_nxt = state;
    if (launch) begin
      state_nxt = ITER;
    end else begin
      case (state)
        ITER:    if (counter == CBITS'(NBITS - 1)) state_nxt = FIX;
        FIX:     state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // a_buf is shifted right so that bit 0 is always the current multiplier bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_start <= 1'b0;
      a_buf      <= '0;
      b_buf      <= '0;
      n_buf      <= '0;
      m          <= '0;
      counter    <= '0;
      out        <= '0;
      done       <= 1'b1;
    end else begin
      prev_start <= start;
      if (launch) begin
        a_buf   <= A;
        b_buf   <= B;
        n_buf   <= N;
        m       <= '0;
        counter <= '0;
        done    <= 1'b0;
      end else begin
        case (state)
          ITER: begin
            m       <= m_next;
            a_buf   <= a_buf >> 1;
            counter <= counter + CBITS'(1);
          end
          FIX: begin
            out  <= NBITS'(fix_val);
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mont_mul.sv
// Bench for mont_mul: an 8-bit and a 256-bit instance checked against a
// closed-form REDC model (A*B + k*N) / R mod N with k = -A*B*N^-1 mod R.
module tb_mont_mul;
  import rsa_pkg::*;

  localparam int BUDGET = 400;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start8, start256;
  logic [7:0]   a8, b8, n8, out8;
  logic [255:0] a256, b256, n256, out256;
  logic         done8, done256;
  state_t       state8, state256;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mont_mul #(.NBITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .N(n8),
    .out(out8), .done(done8), .state_dbg(state8)
  );

  mont_mul #(.NBITS(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .A(a256), .B(b256), .N(n256),
    .out(out256), .done(done256), .state_dbg(state256)
  );

  // ---------------- reference model ----------------
  function automatic logic [255:0] ref_mont(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] n, input int nb);
    logic [767:0] rm, nw, inv, ab, k, t, q;
    rm  = (768'd1 << nb) - 768'd1;
    nw  = {512'd0, n};
    inv = nw;
    for (int i = 0; i < 9; i++) inv = (inv * (768'd2 - ((nw * inv) & rm))) & rm;
    ab = {512'd0, a} * {512'd0, b};
    k  = (768'd0 - ((ab * inv) & rm)) & rm;
    t  = (ab + k * nw) >> nb;
    q  = t % nw;
    return q[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input bit big);
    return big ? done256 : done8;
  endfunction

  function automatic logic [255:0] get_out(input bit big);
    return big ? out256 : {248'd0, out8};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input bit big, input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] n, input logic s);
    if (big) begin
      a256 = a; b256 = b; n256 = n; start256 = s;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; n8 = n[7:0]; start8 = s;
    end
  endtask

  // Counts edges after the current point until done is seen high.
  task automatic wait_done(input bit big, output int cyc);
    cyc = 0;
    while (!get_done(big) && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input bit big, input logic [255:0] a, input logic [255:0] b,
                        input logic [255:0] n, input logic [255:0] exp, input string tag);
    int cyc;
    int nb;
    nb = big ? 256 : 8;
    @(posedge clk); @(negedge clk);
    drive(big, a, b, n, 1'b0);
    #1 chk({tag, "_done_pre"}, {255'd0, get_done(big)}, 256'd1);
    @(posedge clk); #1;
    chk({tag, "_busy"}, {255'd0, get_done(big)}, 256'd0);
    // Operands change after launch; the result must not depend on them.
    drive(big, rand256(), rand256(), rand256(), 1'b1);
    wait_done(big, cyc);
    chk({tag, "_lat"}, cyc, nb + 1);
    chk({tag, "_out"}, get_out(big), exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] a, b, n;
    int           cyc;
    bit           relaunched;

    rst_n = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done8", {255'd0, done8}, 256'd1);
    chk("rst_out8", {248'd0, out8}, 256'd0);
    chk("rst_done256", {255'd0, done256}, 256'd1);
    chk("rst_out256", out256, 256'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("lowrst_nolaunch8", {255'd0, done8}, 256'd1);
    chk("lowrst_nolaunch256", {255'd0, done256}, 256'd1);
    @(negedge clk);
    start8 = 1'b1; start256 = 1'b1;

    run_op(1'b0, 5, 7, 13, 1, "d8_5x7");
    run_op(1'b0, 9, 7, 13, 7, "d8_9x7");
    run_op(1'b0, 0, 12, 13, 0, "d8_0x12");

    // Restart mid-operation with new operands.
    @(posedge clk); @(negedge clk);
    drive(1'b0, 5, 7, 13, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 5, 7, 13, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    chk("rs_busy", {255'd0, done8}, 256'd0);
    @(negedge clk);
    drive(1'b0, 9, 7, 13, 1'b0);
    @(posedge clk); #1;
    chk("rs_busy2", {255'd0, done8}, 256'd0);
    drive(1'b0, rand256(), rand256(), rand256(), 1'b1);
    wait_done(1'b0, cyc);
    chk("rs_lat", cyc, 9);
    chk("rs_out", {248'd0, out8}, 256'd7);

    // start held low for 20 cycles launches exactly once.
    @(posedge clk); @(negedge clk);
    drive(1'b0, 5, 7, 13, 1'b0);
    @(posedge clk); #1;
    wait_done(1'b0, cyc);
    chk("hold_lat", cyc, 9);
    relaunched = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
      if (!done8) relaunched = 1'b1;
    end
    chk("hold_once", {255'd0, relaunched}, 256'd0);
    chk("hold_out", {248'd0, out8}, 256'd1);
    @(negedge clk) start8 = 1'b1;

    for (int i = 0; i < 12; i++) begin
      n = 256'($urandom_range(1, 127) * 2 + 1);
      a = 256'($urandom_range(0, int'(n[7:0]) - 1));
      b = 256'($urandom_range(0, int'(n[7:0]) - 1));
      run_op(1'b0, a, b, n, ref_mont(a, b, n, 8), $sformatf("r8_%0d", i));
    end

    n = 256'd0 - 256'd189;
    run_op(1'b1, 189, 12345, n, 12345, "d256_rmod");

    // Asynchronous reset in the middle of a 256-bit operation.
    @(posedge clk); @(negedge clk);
    drive(1'b1, rand256() % n, rand256() % n, n, 1'b0);
    @(posedge clk); #1;
    start256 = 1'b1;
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done", {255'd0, done256}, 256'd1);
    chk("arst_out", out256, 256'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      n = rand256() | {1'b1, 255'd1};
      a = rand256() % n;
      b = rand256() % n;
      run_op(1'b1, a, b, n, ref_mont(a, b, n, 256), $sformatf("r256_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
